// File: rtl/peripheral_fifo.sv
// peripheral_fifo: CPU-mapped 16-bit FIFO with status/control registers and optional threshold irq.
// Define FIFO_IRQ_EN to build the THRESH register and the level interrupt.
module peripheral_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic        irq
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [15:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rptr, wptr;
    logic [DEPTH_LOG2:0] count;
    logic ovf, unf, empty, full;
    logic wr_acc, rd_acc, push, pop, push_ok, pop_ok, flush, clr;
    logic [15:0] status, thresh_rd;
    // a simultaneous write wins; the read then has no side effects
    assign wr_acc  = cs && wr;
    assign rd_acc  = cs && rd && !wr;
    assign push    = wr_acc && addr == 4'h0;
    assign pop     = rd_acc && addr == 4'h2;
    assign flush   = wr_acc && addr == 4'h6 && d_in[0];
    assign clr     = wr_acc && addr == 4'h6 && d_in[1];
    assign empty   = count == '0;
    assign full    = count == (DEPTH_LOG2 + 1)'(DEPTH);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign status  = {8'(count), 3'b000, irq, unf, ovf, full, empty};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (flush) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (push_ok) wptr <= wptr + 1'b1;
                if (pop_ok) rptr <= rptr + 1'b1;
                count <= push_ok ? count + 1'b1 : pop_ok ? count - 1'b1 : count;
            end
            ovf <= !clr && (ovf || (push && full));
            unf <= !clr && (unf || (pop && empty));
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= d_in;
    end
`ifdef FIFO_IRQ_EN
    logic [DEPTH_LOG2:0] thresh;
    // irq is registered, so it lags the count change by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thresh <= (DEPTH_LOG2 + 1)'(1);
            irq    <= 1'b0;
        end else begin
            if (wr_acc && addr == 4'h8) thresh <= d_in[DEPTH_LOG2:0];
            irq <= count >= thresh && thresh != '0;
        end
    end
    assign thresh_rd = 16'(thresh);
`else
    assign irq       = 1'b0;
    assign thresh_rd = '0;
`endif
    always_comb begin
        d_out = !(cs && rd)   ? 16'h0000 :
                addr == 4'h2  ? (empty ? 16'h0000 : mem[rptr]) :
                addr == 4'h4  ? status :
                addr == 4'h8  ? thresh_rd : 16'h0000;
    end
endmodule

// File: doc/peripheral_fifo.md
PERIPHERAL_FIFO -- requirements
Module: peripheral_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, SHALL set FIFO depth to 2**DEPTH_LOG2 entries of 16 bits (legal range 2..7).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 d_in  input  16  write data from the CPU I/O bus.
REQ-005 cs  input  1  chip select from the SoC address decoder; bus strobes SHALL be ignored when cs=0.
REQ-006 addr  input  4  register offset, taken from I/O address bits [3:0].
REQ-007 rd  input  1  read strobe, one cycle per access.
REQ-008 wr  input  1  write strobe, one cycle per access.
REQ-009 d_out  output  16  read data back to the CPU.
REQ-010 irq  output  1  level interrupt, active high.

Function
REQ-011 Register map: 0x0 DATA_W (write: push); 0x2 DATA_R (read: pop); 0x4 STATUS (read-only); 0x6 CTRL (write-only); 0x8 THRESH (read/write); other offsets SHALL read 0x0000 and SHALL ignore writes.
REQ-012 A write SHALL be recognised on the clock edge where cs=1 and wr=1; a read SHALL be recognised on the clock edge where cs=1 and rd=1.
REQ-013 If rd and wr are both high in one cycle, the write SHALL take effect and the read SHALL cause no pop and no flag change.
REQ-014 d_out SHALL be combinational: when cs=1 and rd=1 it SHALL present the addressed register; otherwise it SHALL be 0x0000.
REQ-015 DATA_R SHALL present the head entry while rd is high; the pop (read-pointer increment) SHALL occur on that same clock edge, so the next entry is visible one cycle later.
REQ-016 Push on full: data dropped, pointers and count unchanged, sticky OVF set.
REQ-017 Pop on empty: d_out 0x0000, pointers unchanged, sticky UNF set.
REQ-018 Read and write pointers SHALL be DEPTH_LOG2 bits and SHALL wrap modulo depth.
REQ-019 count SHALL be DEPTH_LOG2+1 bits, range 0..depth; empty=(count==0); full=(count==depth).
REQ-020 STATUS = {count zero-extended to 8 bits in [15:8], 3'b0, irq[4], UNF[3], OVF[2], full[1], empty[0]}.
REQ-021 CTRL bit0=1 SHALL flush (pointers and count to 0, RAM contents don't-care); bit1=1 SHALL clear OVF and UNF; both bits may be set together; CTRL SHALL not be stored.
REQ-022 Each accepted push or pop SHALL change count by exactly 1 on the same edge; STATUS read in the following cycle SHALL reflect it.

Reset
REQ-023 rst low SHALL immediately clear the pointers, count, OVF and UNF, set THRESH to 0x0001, and drive irq=0; d_out follows REQ-014.
REQ-024 Reset asserted mid-operation SHALL discard all FIFO contents; the first access after release SHALL see empty=1.
REQ-025 FIFO storage SHALL not be reset.

Configuration
REQ-026 Macro FIFO_IRQ_EN defined: THRESH is a read/write register whose bits [DEPTH_LOG2:0] are stored and whose upper bits read 0; irq = (count >= THRESH) and (THRESH != 0), registered, so it updates one cycle after the count change.
REQ-027 FIFO_IRQ_EN undefined: no THRESH storage; offset 0x8 reads 0x0000 and ignores writes; irq tied 0; STATUS[4]=0.

Verification
REQ-028 After reset, read STATUS -> 0x0001; read DATA_R -> 0x0000, then STATUS -> 0x0009 (UNF set).
REQ-029 Push 0x1234, 0xABCD, then pop twice -> 0x1234, 0xABCD in order; STATUS -> 0x0001.
REQ-030 DEPTH_LOG2=4: push 17 words 0x0000..0x0010 -> STATUS 0x1006 (count 16, full, OVF); 16 pops return 0x0000..0x000F.
REQ-031 Wrap: push 10 / pop 10, three times, with distinct data -> FIFO order preserved; count returns to 0 each time.
REQ-032 FIFO_IRQ_EN, THRESH=3: push 3 words -> irq rises one cycle after the 3rd push; one pop -> irq falls; CTRL=0x0001 -> count 0, irq 0.
REQ-033 rd and wr high together on DATA_R/DATA_W -> word pushed, no pop, count +1; rst pulsed with 5 entries -> STATUS 0x0001 immediately after release.
